// File: rtl/draw_rectangle_overlay_if.sv
// Video stream bundle for the rectangle overlay stage.
// Carries the incoming pixel/timing bus, detector controls and delayed outputs.
interface draw_rectangle_overlay_if #(
    parameter int CNT_W = 11,
    parameter int RGB_W = 12
);
    logic [CNT_W-1:0] hcount_in;
    logic [CNT_W-1:0] vcount_in;
    logic             hsync_in;
    logic             vsync_in;
    logic             hblnk_in;
    logic             vblnk_in;
    logic [RGB_W-1:0] rgb_in;
    logic             detected_flag;
    logic             continuous;

    logic [CNT_W-1:0] hcount_out;
    logic [CNT_W-1:0] vcount_out;
    logic             hsync_out;
    logic             vsync_out;
    logic             hblnk_out;
    logic             vblnk_out;
    logic             nblank_out;
    logic [RGB_W-1:0] rgb_out;

    modport master (
        output hcount_in, vcount_in,
        output hsync_in, vsync_in,
        output hblnk_in, vblnk_in,
        output rgb_in,
        output detected_flag, continuous,
        input  hcount_out, vcount_out,
        input  hsync_out, vsync_out,
        input  hblnk_out, vblnk_out,
        input  nblank_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in,
        input  hsync_in, vsync_in,
        input  hblnk_in, vblnk_in,
        input  rgb_in,
        input  detected_flag, continuous,
        output hcount_out, vcount_out,
        output hsync_out, vsync_out,
        output hblnk_out, vblnk_out,
        output nblank_out, rgb_out
    );
endinterface

// File: rtl/draw_rectangle_overlay.sv
// Overlays a fixed rectangular outline on the VGA stream, one pclk latency.
// Outline shown when the detector hit in the previous frame or in continuous mode.
module draw_rectangle_overlay #(
    parameter int              CNT_W      = 11,
    parameter int              RGB_W      = 12,
    parameter int              RECT_X     = 100,
    parameter int              RECT_Y     = 80,
    parameter int              RECT_W     = 120,
    parameter int              RECT_H     = 160,
    parameter int              THICK      = 2,
    parameter logic [RGB_W-1:0] RECT_COLOR = 12'hF00
) (
    input logic                    pclk,
    input logic                    rst,
    draw_rectangle_overlay_if.slave vid
);

    // One extra bit keeps RECT_X+RECT_W etc. from wrapping at the counter width.
    localparam int BW = CNT_W + 1;

    localparam logic [BW-1:0] X_LO  = BW'(RECT_X);
    localparam logic [BW-1:0] X_HI  = BW'(RECT_X + RECT_W - 1);
    localparam logic [BW-1:0] Y_LO  = BW'(RECT_Y);
    localparam logic [BW-1:0] Y_HI  = BW'(RECT_Y + RECT_H - 1);
    localparam logic [BW-1:0] XI_LO = BW'(RECT_X + THICK);
    localparam logic [BW-1:0] XI_HI = BW'(RECT_X + RECT_W - THICK);
    localparam logic [BW-1:0] YI_LO = BW'(RECT_Y + THICK);
    localparam logic [BW-1:0] YI_HI = BW'(RECT_Y + RECT_H - THICK);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             nblank_q, nblank_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic             vblnk_prev_q, vblnk_prev_d;
    logic             det_seen_q, det_seen_d;
    logic             frame_en_q, frame_en_d;

    logic [BW-1:0]    h_w;
    logic [BW-1:0]    v_w;
    logic             in_box;
    logic             on_rim;
    logic             border;
    logic             blank;
    logic             draw_en;
    logic             frame_upd;

    assign h_w = {1'b0, vid.hcount_in};
    assign v_w = {1'b0, vid.vcount_in};

    // Border test: inside the outer box but not inside the inner box.
    always_comb begin
        in_box = 1'b0;
        on_rim = 1'b0;
        border = 1'b0;
        in_box = (h_w >= X_LO) && (h_w <= X_HI)
              && (v_w >= Y_LO) && (v_w <= Y_HI);
        on_rim = (h_w < XI_LO) || (h_w >= XI_HI)
              || (v_w < YI_LO) || (v_w >= YI_HI);
        border = in_box && on_rim;
    end

    assign blank     = vid.hblnk_in | vid.vblnk_in;
    assign frame_upd = vid.vblnk_in & ~vblnk_prev_q;
    assign draw_en   = vid.continuous | frame_en_q;

    // Detection latch and per-frame draw decision, refreshed at vblank rise.
    always_comb begin
        vblnk_prev_d = vid.vblnk_in;
        det_seen_d   = det_seen_q | vid.detected_flag;
        frame_en_d   = frame_en_q;
        if (frame_upd) begin
            det_seen_d = vid.detected_flag;
            frame_en_d = det_seen_q | vid.detected_flag;
        end
    end

    // Pixel mux: blanking beats outline, outline beats source pixel.
    always_comb begin
        rgb_d = vid.rgb_in;
        if (blank) begin
            rgb_d = '0;
        end else if (border && draw_en) begin
            rgb_d = RECT_COLOR;
        end
    end

    // Timing pass-through next-state values.
    always_comb begin
        hcount_d = vid.hcount_in;
        vcount_d = vid.vcount_in;
        hsync_d  = vid.hsync_in;
        vsync_d  = vid.vsync_in;
        hblnk_d  = vid.hblnk_in;
        vblnk_d  = vid.vblnk_in;
        nblank_d = ~blank;
    end

    // Output pipeline register, cleared asynchronously.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            nblank_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            nblank_q <= nblank_d;
            rgb_q    <= rgb_d;
        end
    end

    // Frame-level control state, cleared asynchronously.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vblnk_prev_q <= 1'b0;
            det_seen_q   <= 1'b0;
            frame_en_q   <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            det_seen_q   <= det_seen_d;
            frame_en_q   <= frame_en_d;
        end
    end

    assign vid.hcount_out = hcount_q;
    assign vid.vcount_out = vcount_q;
    assign vid.hsync_out  = hsync_q;
    assign vid.vsync_out  = vsync_q;
    assign vid.hblnk_out  = hblnk_q;
    assign vid.vblnk_out  = vblnk_q;
    assign vid.nblank_out = nblank_q;
    assign vid.rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_rectangle_overlay.sv
// Directed bench for draw_rectangle_overlay.
// Expected pixels are written out by hand from the rectangle geometry.
module tb_draw_rectangle_overlay;

    logic pclk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] SRC = 12'h0F0;
    localparam logic [11:0] RC  = 12'hF00;

    draw_rectangle_overlay_if #(.CNT_W(11), .RGB_W(12)) vif ();

    draw_rectangle_overlay dut (
        .pclk (pclk),
        .rst  (rst),
        .vid  (vif)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic set_px(input int h, input int v, input logic [11:0] rgb,
                          input logic hb, input logic vb);
        vif.hcount_in = 11'(h);
        vif.vcount_in = 11'(v);
        vif.rgb_in    = rgb;
        vif.hblnk_in  = hb;
        vif.vblnk_in  = vb;
    endtask

    task automatic px(input string tag, input int h, input int v,
                      input logic [11:0] exp);
        set_px(h, v, SRC, 1'b0, 1'b0);
        tick();
        chk(tag, 64'(vif.rgb_out), 64'(exp));
    endtask

    task automatic vblank_gap(input logic det_first);
        for (int i = 0; i < 3; i++) begin
            set_px(0, 500, SRC, 1'b0, 1'b1);
            vif.detected_flag = (i == 0) ? det_first : 1'b0;
            tick();
            chk("vblank_rgb", 64'(vif.rgb_out), 64'd0);
        end
        vif.detected_flag = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {vif.hcount_out, vif.vcount_out, vif.rgb_out,
                  vif.hsync_out, vif.vsync_out, vif.hblnk_out,
                  vif.vblnk_out, vif.nblank_out}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hpat;
        logic [15:0] vpat;
        logic [11:0] e;

        rst = 1'b0;
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        vif.detected_flag = 1'b0;
        vif.continuous = 1'b0;
        set_px(0, 0, 12'h000, 1'b0, 1'b0);

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            vif.hcount_in     = 11'($urandom);
            vif.vcount_in     = 11'($urandom);
            vif.rgb_in        = 12'($urandom);
            vif.hsync_in      = 1'($urandom);
            vif.vsync_in      = 1'($urandom);
            vif.hblnk_in      = 1'($urandom);
            vif.vblnk_in      = 1'($urandom);
            vif.detected_flag = 1'($urandom);
            vif.continuous    = 1'($urandom);
            tick();
            chk_all_zero("reset_outs");
        end
        chk("reset_nblank", 64'(vif.nblank_out), 64'd0);

        // release
        vif.detected_flag = 1'b0;
        vif.continuous    = 1'b0;
        vif.hsync_in      = 1'b0;
        vif.vsync_in      = 1'b0;
        rst = 1'b1;
        set_px(5, 7, SRC, 1'b0, 1'b0);
        tick();
        chk("rel_hcount", 64'(vif.hcount_out), 64'd5);
        chk("rel_vcount", 64'(vif.vcount_out), 64'd7);
        chk("rel_nblank", 64'(vif.nblank_out), 64'd1);

        // continuous sweep of top edge row
        vif.continuous = 1'b1;
        for (int h = 0; h <= 300; h++) begin
            e = (h >= 100 && h <= 219) ? RC : SRC;
            px("row80", h, 80, e);
            if (h == 100 || h == 219)
                chk("row80_hcnt", 64'(vif.hcount_out), 64'(h));
        end

        // interior row: only the side bars
        for (int h = 90; h <= 230; h++) begin
            e = (h == 100 || h == 101 || h == 218 || h == 219) ? RC : SRC;
            px("row200", h, 200, e);
        end

        // horizontal edges and rows just outside
        for (int h = 98; h <= 221; h++) begin
            e = (h >= 100 && h <= 219) ? RC : SRC;
            px("row79", h, 79, SRC);
            px("row81", h, 81, e);
            px("row82", h, 82, (h == 100 || h == 101 ||
                                h == 218 || h == 219) ? RC : SRC);
            px("row238", h, 238, e);
            px("row239", h, 239, e);
            px("row240", h, 240, SRC);
        end

        // counters beyond the frame never hit
        px("wrap_h", 2047, 80, SRC);
        px("wrap_v", 150, 2047, SRC);

        // blanking priority
        set_px(100, 80, SRC, 1'b1, 1'b0);
        tick();
        chk("hblnk_rgb", 64'(vif.rgb_out), 64'd0);
        chk("hblnk_nb", 64'(vif.nblank_out), 64'd0);
        chk("hblnk_out", 64'(vif.hblnk_out), 64'd1);
        set_px(100, 80, SRC, 1'b0, 1'b1);
        tick();
        chk("vblnk_rgb", 64'(vif.rgb_out), 64'd0);
        chk("vblnk_nb", 64'(vif.nblank_out), 64'd0);
        chk("vblnk_out", 64'(vif.vblnk_out), 64'd1);
        px("unblank", 100, 80, RC);
        chk("unblank_nb", 64'(vif.nblank_out), 64'd1);

        // continuous drop acts on the next pixel
        vif.continuous = 1'b0;
        px("cont_off", 100, 80, SRC);

        // detection latch: pulse mid-frame N
        vblank_gap(1'b0);
        px("fN_pre", 100, 120, SRC);
        vif.detected_flag = 1'b1;
        px("fN_pulse", 160, 130, SRC);
        vif.detected_flag = 1'b0;
        px("fN_post", 101, 200, SRC);
        vblank_gap(1'b0);
        px("fN1_tl", 100, 80, RC);
        px("fN1_br", 219, 239, RC);
        px("fN1_in", 150, 150, SRC);
        vblank_gap(1'b0);
        px("fN2_tl", 100, 80, SRC);

        // detection on the update cycle itself
        vblank_gap(1'b1);
        px("fU1", 100, 80, RC);
        vblank_gap(1'b0);
        px("fU2", 100, 80, RC);
        vblank_gap(1'b0);
        px("fU3", 100, 80, SRC);

        // asynchronous reset mid-frame
        vblank_gap(1'b1);
        px("pre_rst", 100, 80, RC);
        set_px(200, 90, SRC, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk_all_zero("rst_hold");
        rst = 1'b1;
        px("post_rst", 100, 80, SRC);
        chk("post_rst_h", 64'(vif.hcount_out), 64'd100);
        px("post_rst2", 219, 200, SRC);
        vblank_gap(1'b0);
        px("post_rst_f", 100, 80, SRC);

        // sync pass-through
        hpat = 16'b1011_0010_1110_0101;
        vpat = 16'b0110_1001_0001_1110;
        for (int i = 0; i < 16; i++) begin
            set_px(10, 10, SRC, 1'b0, 1'b0);
            vif.hsync_in = hpat[i];
            vif.vsync_in = vpat[i];
            tick();
            chk("hsync", 64'(vif.hsync_out), 64'(hpat[i]));
            chk("vsync", 64'(vif.vsync_out), 64'(vpat[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_rectangle_overlay.md
# draw_rectangle_overlay

Pixel-pipeline stage that overlays a fixed-position rectangular outline on the VGA video stream. The outline marks the face-detection window. It is shown when the detector reports a hit, or on every frame when continuous mode is selected. The stage sits between the camera/frame-buffer readout (which supplies counters, syncs, blanking and pixel data) and the VGA output driver. It forwards all timing signals delayed by exactly one pixel clock.

## Interface
Parameters:
- CNT_W, 11, width of hcount/vcount buses
- RGB_W, 12, pixel data width
- RECT_X, 100, left column of rectangle
- RECT_Y, 80, top row of rectangle
- RECT_W, 120, rectangle width in pixels
- RECT_H, 160, rectangle height in pixels
- THICK, 2, outline thickness in pixels
- RECT_COLOR, 12'hF00, outline colour (RGB_W bits)

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- hcount_in / vcount_in  in  CNT_W  current pixel column / row
- hsync_in / vsync_in  in  1  syncs
- hblnk_in / vblnk_in  in  1  blanking, active-high
- rgb_in  in  RGB_W  source pixel
- detected_flag  in  1  detector hit for current frame (level, any cycle)
- continuous  in  1  1 = draw outline every frame regardless of detection
- hcount_out / vcount_out  out  CNT_W  delayed counters
- hsync_out / vsync_out  out  1  delayed syncs
- hblnk_out / vblnk_out  out  1  delayed blanking
- nblank_out  out  1  ~(hblnk_in | vblnk_in), delayed
- rgb_out  out  RGB_W  output pixel

## Operation
- Border pixel: RECT_X ≤ h ≤ RECT_X+RECT_W−1 and RECT_Y ≤ v ≤ RECT_Y+RECT_H−1, and at least one of: h < RECT_X+THICK, h ≥ RECT_X+RECT_W−THICK, v < RECT_Y+THICK, v ≥ RECT_Y+RECT_H−THICK. Comparisons unsigned, CNT_W+1 bits internally to avoid overflow.
- det_seen register: set on any cycle with detected_flag=1; cleared on the frame-update cycle unless detected_flag=1 on that same cycle, in which case it remains set.
- Frame-update cycle: first cycle with vblnk_in=1 after a cycle with vblnk_in=0 (rising edge, detected with a registered copy of vblnk_in).
- frame_en register: on the frame-update cycle loads (det_seen | detected_flag); otherwise holds. The rectangle decision is therefore stable for a whole visible frame.
- Draw enable = continuous | frame_en. continuous is combinational into the decision, so it takes effect on the next pixel.
- rgb_out priority:
  - blanking (hblnk_in | vblnk_in) → 0
  - else border pixel and draw enable → RECT_COLOR
  - else rgb_in
- All timing outputs are pass-through copies of the inputs, registered once.

## Timing
- Latency: every output is exactly 1 pclk after its inputs. rgb_out always stays aligned with hcount_out / vcount_out.
- Reset (rst=0, asynchronous): all outputs 0, nblank_out 0, det_seen 0, frame_en 0, vblnk edge register 0. The first frame after reset draws only if continuous=1.
- Reset deasserts synchronously to the design. The first registered outputs appear on the first pclk edge with rst=1.
- Reset mid-frame: outputs drop to 0 immediately. Pass-through resumes 1 cycle after release; frame_en stays 0 until the next frame-update cycle.
- No handshake. The stage is free-running and accepts a new pixel every cycle.
- Counter values outside the rectangle, including wrap-around at line or frame end, simply fail the border test. The block has no state tied to counter sequence.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release; hcount_in=5, vcount_in=7 → hcount_out=5, vcount_out=7 one cycle later.
- Continuous draw: continuous=1, detected_flag=0, vcount=80, sweep hcount 0..300 unblanked, rgb_in=12'h0F0. Required rgb_out: 12'hF00 for h=100..219, 12'h0F0 elsewhere, each value 1 cycle after its input.
- Interior/edge rows: continuous=1, vcount=200. Required rgb_out: 12'hF00 only at h=100,101,218,219; rgb_in elsewhere. At vcount=239 the whole span 100..219 is RECT_COLOR; at vcount=240 none is.
- Detection latch: continuous=0; pulse detected_flag for one cycle mid-frame N. Frame N shows no outline; frame N+1 (after vblnk rise) shows the outline; frame N+2 with no pulse shows no outline.
- Blanking priority: continuous=1, h=100, v=80, hblnk_in=1 → rgb_out=0 and nblank_out=0. Same point with vblnk_in=1 → rgb_out=0.
- Sync pass-through: toggle hsync_in/vsync_in in arbitrary patterns → hsync_out/vsync_out reproduce the patterns exactly, delayed 1 cycle.
